biriscv_v_writeback: RTL and testbench

BIRISCV_V_WRITEBACK -- requirements
Module: biriscv_v_writeback

---
 rtl/biriscv_v_writeback.sv | 146 ++++++++++++++
 tb/tb_biriscv_v_writeback.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_v_writeback.sv
// biriscv_v_writeback
//   Vector writeback stage. It accepts one vector ALU result at a time and
//   commits it to the vector register file. Unmasked results are written
//   directly. Masked results first read the old destination register, then
//   merge per element (mask-undisturbed), then write.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-low reset
//   res_*               result handshake: valid/ready, data, mask, vm, vd
//   vrf_rd_*            old-vd read request; data is returned the cycle after
//   vrf_wr_*            register file write strobe, index and data
//   wb_done_o, wb_vd_o  one-cycle commit pulse with the committed index
//   wb_count_o          running count of committed writes (wraps)
module biriscv_v_writeback #(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            res_valid_i,
  output logic            res_ready_o,
  input  logic [VLEN-1:0] res_data_i,
  input  logic [VLEN-1:0] res_mask_i,
  input  logic            res_vm_i,
  input  logic [4:0]      res_vd_i,
  output logic            vrf_rd_en_o,
  output logic [4:0]      vrf_rd_addr_o,
  input  logic [VLEN-1:0] vrf_rd_data_i,
  output logic            vrf_wr_en_o,
  output logic [4:0]      vrf_wr_addr_o,
  output logic [VLEN-1:0] vrf_wr_data_o,
  output logic            wb_done_o,
  output logic [4:0]      wb_vd_o,
  output logic [31:0]     wb_count_o
);

  localparam int NUM_ELEM = VLEN / ELEN;

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;

  state_t              state;
  logic [VLEN-1:0]     cap_data;
  logic [NUM_ELEM-1:0] cap_en;
  logic                cap_vm;
  logic [4:0]          cap_vd;

  logic [NUM_ELEM-1:0] mask_en;
  logic [VLEN-1:0]     merged;
  logic                unused_mask;

  // Only the lowest bit of each element's mask slice is meaningful; the
  // rest are folded into an unused net.
  always_comb begin
    mask_en = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      mask_en[i] = res_mask_i[i*ELEN];
    end
  end

  assign unused_mask = ^res_mask_i;

  // Mask-undisturbed merge: enabled elements come from the result, the rest
  // keep the old register contents.
  always_comb begin
    merged = vrf_rd_data_i;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (cap_en[i]) begin
        merged[i*ELEN +: ELEN] = cap_data[i*ELEN +: ELEN];
      end
    end
    if (cap_vm) begin
      merged = cap_data;
    end
  end

  // Ready is gated by reset so it reads low while reset is held and high
  // in the very first cycle after release.
  assign res_ready_o = (state == IDLE) && rst_i;

  // Single FSM with registered strobes. The strobes are set on the edge
  // that enters READ/WRITE so they are high exactly while in that state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      cap_data      <= '0;
      cap_en        <= '0;
      cap_vm        <= 1'b0;
      cap_vd        <= '0;
      vrf_rd_en_o   <= 1'b0;
      vrf_rd_addr_o <= '0;
      vrf_wr_en_o   <= 1'b0;
      vrf_wr_addr_o <= '0;
      vrf_wr_data_o <= '0;
      wb_done_o     <= 1'b0;
      wb_vd_o       <= '0;
      wb_count_o    <= '0;
    end else begin
      vrf_rd_en_o <= 1'b0;
      vrf_wr_en_o <= 1'b0;
      wb_done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (res_valid_i) begin
            cap_data <= res_data_i;
            cap_en   <= mask_en;
            cap_vm   <= res_vm_i;
            cap_vd   <= res_vd_i;
            if (res_vm_i) begin
              // Unmasked results skip the old-vd read entirely.
              state         <= WRITE;
              vrf_wr_en_o   <= 1'b1;
              wb_done_o     <= 1'b1;
              vrf_wr_addr_o <= res_vd_i;
              wb_vd_o       <= res_vd_i;
              vrf_wr_data_o <= res_data_i;
            end else begin
              state         <= READ;
              vrf_rd_en_o   <= 1'b1;
              vrf_rd_addr_o <= res_vd_i;
            end
          end
        end
        READ: begin
          state <= MERGE;
        end
        MERGE: begin
          // Old vd data is on vrf_rd_data_i during this cycle.
          state         <= WRITE;
          vrf_wr_en_o   <= 1'b1;
          wb_done_o     <= 1'b1;
          vrf_wr_addr_o <= cap_vd;
          wb_vd_o       <= cap_vd;
          vrf_wr_data_o <= merged;
        end
        WRITE: begin
          state      <= IDLE;
          wb_count_o <= wb_count_o + 32'd1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biriscv_v_writeback.sv
// tb_biriscv_v_writeback
//   Directed, table-driven bench for biriscv_v_writeback (VLEN=128,
//   ELEN=32), plus hand-written sequences for back-to-back results, reset
//   during MERGE and write-counter wrap.
module tb_biriscv_v_writeback;

  logic         clk_i;
  logic         rst_i;
  logic         res_valid_i;
  logic         res_ready_o;
  logic [127:0] res_data_i;
  logic [127:0] res_mask_i;
  logic         res_vm_i;
  logic [4:0]   res_vd_i;
  logic         vrf_rd_en_o;
  logic [4:0]   vrf_rd_addr_o;
  logic [127:0] vrf_rd_data_i;
  logic         vrf_wr_en_o;
  logic [4:0]   vrf_wr_addr_o;
  logic [127:0] vrf_wr_data_o;
  logic         wb_done_o;
  logic [4:0]   wb_vd_o;
  logic [31:0]  wb_count_o;

  int compared;
  int mismatched;
  logic [31:0] exp_count;

  typedef struct {
    logic         vm;
    logic [4:0]   vd;
    logic [127:0] data;
    logic [127:0] mask;
    logic [127:0] old;
    logic [127:0] expected;
  } vec_t;

  vec_t vecs[6];

  biriscv_v_writeback #(.VLEN(128), .ELEN(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .res_data_i    (res_data_i),
    .res_mask_i    (res_mask_i),
    .res_vm_i      (res_vm_i),
    .res_vd_i      (res_vd_i),
    .vrf_rd_en_o   (vrf_rd_en_o),
    .vrf_rd_addr_o (vrf_rd_addr_o),
    .vrf_rd_data_i (vrf_rd_data_i),
    .vrf_wr_en_o   (vrf_wr_en_o),
    .vrf_wr_addr_o (vrf_wr_addr_o),
    .vrf_wr_data_o (vrf_wr_data_o),
    .wb_done_o     (wb_done_o),
    .wb_vd_o       (wb_vd_o),
    .wb_count_o    (wb_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Run one result through the block from IDLE back to IDLE, checking the
  // read request, merged write and commit counter along the way.
  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    check_output({tag, ".ready"}, 128'(res_ready_o), 128'd1);
    res_valid_i   = 1'b1;
    res_vm_i      = v.vm;
    res_vd_i      = v.vd;
    res_data_i    = v.data;
    res_mask_i    = v.mask;
    vrf_rd_data_i = v.old;
    step();
    res_valid_i = 1'b0;
    res_data_i  = '0;
    if (!v.vm) begin
      check_output({tag, ".rd_en"}, 128'(vrf_rd_en_o), 128'd1);
      check_output({tag, ".rd_addr"}, 128'(vrf_rd_addr_o), 128'(v.vd));
      check_output({tag, ".wr_en_read"}, 128'(vrf_wr_en_o), 128'd0);
      step();
      check_output({tag, ".rd_en_merge"}, 128'(vrf_rd_en_o), 128'd0);
      check_output({tag, ".wr_en_merge"}, 128'(vrf_wr_en_o), 128'd0);
      step();
    end
    check_output({tag, ".wr_en"}, 128'(vrf_wr_en_o), 128'd1);
    check_output({tag, ".wr_addr"}, 128'(vrf_wr_addr_o), 128'(v.vd));
    check_output({tag, ".wr_data"}, vrf_wr_data_o, v.expected);
    check_output({tag, ".done"}, 128'(wb_done_o), 128'd1);
    check_output({tag, ".wb_vd"}, 128'(wb_vd_o), 128'(v.vd));
    check_output({tag, ".ready_write"}, 128'(res_ready_o), 128'd0);
    step();
    exp_count = exp_count + 32'd1;
    check_output({tag, ".wr_en_after"}, 128'(vrf_wr_en_o), 128'd0);
    check_output({tag, ".count"}, 128'(wb_count_o), 128'(exp_count));
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    exp_count   = '0;

    vecs[0] = '{vm: 1'b1, vd: 5'd3,
                data: 128'h00000004_00000003_00000002_00000001,
                mask: 128'h0,
                old: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                expected: 128'h00000004_00000003_00000002_00000001};
    vecs[1] = '{vm: 1'b0, vd: 5'd5,
                data: 128'h00000000_00000030_00000000_00000010,
                mask: 128'h00000000_00000001_00000000_00000001,
                old: 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                expected: 128'hDDDDDDDD_00000030_BBBBBBBB_00000010};
    vecs[2] = '{vm: 1'b0, vd: 5'd7,
                data: 128'h0,
                mask: 128'h0,
                old: 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978,
                expected: 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978};
    // Non-element mask bits set everywhere; only bit 0 cleared.
    vecs[3] = '{vm: 1'b0, vd: 5'd17,
                data: 128'h11111111_22222222_33333333_00000000,
                mask: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE,
                old: 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
                expected: 128'h11111111_22222222_33333333_DDDDDDDD};
    // Unmasked op ignores both mask and old data.
    vecs[4] = '{vm: 1'b1, vd: 5'd31,
                data: 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF,
                mask: 128'h0,
                old: 128'h55555555_55555555_55555555_55555555,
                expected: 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF};
    vecs[5] = '{vm: 1'b0, vd: 5'd0,
                data: 128'h80000000_00000000_00000000_00000000,
                mask: 128'h00000001_00000000_00000000_00000000,
                old: 128'h01010101_02020202_03030303_04040404,
                expected: 128'h80000000_02020202_03030303_04040404};

    rst_i         = 1'b0;
    res_valid_i   = 1'b0;
    res_data_i    = '0;
    res_mask_i    = '0;
    res_vm_i      = 1'b0;
    res_vd_i      = '0;
    vrf_rd_data_i = '0;

    // Reset state.
    step();
    step();
    check_output("rst.ready", 128'(res_ready_o), 128'd0);
    check_output("rst.rd_en", 128'(vrf_rd_en_o), 128'd0);
    check_output("rst.wr_en", 128'(vrf_wr_en_o), 128'd0);
    check_output("rst.done", 128'(wb_done_o), 128'd0);
    check_output("rst.wr_data", vrf_wr_data_o, 128'd0);
    check_output("rst.addrs", 128'({vrf_rd_addr_o, vrf_wr_addr_o, wb_vd_o}), 128'd0);
    check_output("rst.count", 128'(wb_count_o), 128'd0);
    rst_i = 1'b1;
    #1;
    check_output("rst.ready_release", 128'(res_ready_o), 128'd1);
    step();

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Back-to-back with valid held: unmasked then masked.
    res_valid_i   = 1'b1;
    res_vm_i      = 1'b1;
    res_vd_i      = 5'd9;
    res_data_i    = 128'h99999999_88888888_77777777_66666666;
    res_mask_i    = '0;
    vrf_rd_data_i = 128'hA0A0A0A0_B0B0B0B0_C0C0C0C0_D0D0D0D0;
    step();
    res_vm_i   = 1'b0;
    res_vd_i   = 5'd10;
    res_data_i = 128'h00000000_00000000_00000042_00000000;
    res_mask_i = 128'h00000000_00000000_00000001_00000000;
    check_output("b2b.wr1_addr", 128'(vrf_wr_addr_o), 128'd9);
    check_output("b2b.wr1_data", vrf_wr_data_o, 128'h99999999_88888888_77777777_66666666);
    check_output("b2b.ready_gap1", 128'(res_ready_o), 128'd0);
    step();
    check_output("b2b.ready_back1", 128'(res_ready_o), 128'd1);
    check_output("b2b.wr_en_idle", 128'(vrf_wr_en_o), 128'd0);
    step();
    res_valid_i = 1'b0;
    check_output("b2b.rd_en2", 128'(vrf_rd_en_o), 128'd1);
    check_output("b2b.rd_addr2", 128'(vrf_rd_addr_o), 128'd10);
    check_output("b2b.ready_gap2a", 128'(res_ready_o), 128'd0);
    step();
    check_output("b2b.ready_gap2b", 128'(res_ready_o), 128'd0);
    step();
    check_output("b2b.ready_gap2c", 128'(res_ready_o), 128'd0);
    check_output("b2b.wr2_en", 128'(vrf_wr_en_o), 128'd1);
    check_output("b2b.wr2_addr", 128'(vrf_wr_addr_o), 128'd10);
    check_output("b2b.wr2_data", vrf_wr_data_o, 128'hA0A0A0A0_B0B0B0B0_00000042_D0D0D0D0);
    step();
    exp_count = exp_count + 32'd2;
    check_output("b2b.ready_back2", 128'(res_ready_o), 128'd1);
    check_output("b2b.count", 128'(wb_count_o), 128'(exp_count));

    // Reset asserted while in MERGE drops the result.
    res_valid_i = 1'b1;
    res_vm_i    = 1'b0;
    res_vd_i    = 5'd12;
    res_data_i  = 128'h1;
    res_mask_i  = 128'h1;
    step();
    res_valid_i = 1'b0;
    step();
    rst_i = 1'b0;
    #1;
    check_output("mrst.wr_en", 128'(vrf_wr_en_o), 128'd0);
    check_output("mrst.count", 128'(wb_count_o), 128'd0);
    check_output("mrst.ready_in_reset", 128'(res_ready_o), 128'd0);
    step();
    check_output("mrst.wr_en_held", 128'(vrf_wr_en_o), 128'd0);
    rst_i = 1'b1;
    #1;
    check_output("mrst.ready_release", 128'(res_ready_o), 128'd1);
    step();
    check_output("mrst.wr_en_post", 128'(vrf_wr_en_o), 128'd0);
    check_output("mrst.count_post", 128'(wb_count_o), 128'd0);

    // Counter wrap: preload the counter to all ones, then commit once.
    force dut.wb_count_o = 32'hFFFFFFFF;
    #1;
    release dut.wb_count_o;
    #1;
    res_valid_i = 1'b1;
    res_vm_i    = 1'b1;
    res_vd_i    = 5'd1;
    res_data_i  = 128'h5;
    step();
    res_valid_i = 1'b0;
    check_output("wrap.wr_en", 128'(vrf_wr_en_o), 128'd1);
    step();
    check_output("wrap.count", 128'(wb_count_o), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
